// File: rtl/floor_pkg.sv
// Shared definitions for the floor scroll scheduler and its helpers:
// state encoding, slot geometry and default screen bounds.
package floor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int Y_W       = 10;

    localparam logic [9:0]  TOP_Y_DEFAULT        = 10'd40;
    localparam logic [9:0]  BOTTOM_Y_DEFAULT     = 10'd470;
    localparam logic [9:0]  X_MIN_DEFAULT        = 10'd40;
    localparam logic [9:0]  X_SPAN_DEFAULT       = 10'd480;
    localparam logic [11:0] LEVEL_FRAMES_DEFAULT = 12'd1200;
    localparam logic [9:0]  LFSR_SEED_DEFAULT    = 10'h2A5;

    // Folds a 9-bit random value into [x_min, x_min + x_span); one subtraction
    // suffices because x_span is at least 256.
    function automatic logic [9:0] wrap_x(input logic [9:0] rnd,
                                          input logic [9:0] x_min,
                                          input logic [9:0] x_span);
        logic [9:0] r;
        r = {1'b0, rnd[8:0]};
        if (r >= x_span) begin
            r = r - x_span;
        end
        return x_min + r;
    endfunction

endpackage

// File: rtl/floor_lfsr10.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1); a nonzero seed keeps
// it out of the all-zero lock-up state.
module floor_lfsr10 #(
    parameter logic [9:0] SEED = 10'h2A5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] lfsr
);

    logic [9:0] lfsr_reg;
    logic [9:0] lfsr_next;

    assign lfsr_next = {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign lfsr = lfsr_reg;

endmodule

// File: rtl/floor_scroll_sched.sv
// Floor generator sequencer: paces scroll steps per frame with four speed
// levels and issues one-at-a-time respawn requests for floors that left the screen.
module floor_scroll_sched
    import floor_pkg::*;
#(
    parameter logic [9:0]  TOP_Y        = TOP_Y_DEFAULT,
    parameter logic [9:0]  BOTTOM_Y     = BOTTOM_Y_DEFAULT,
    parameter logic [9:0]  X_MIN        = X_MIN_DEFAULT,
    parameter logic [9:0]  X_SPAN       = X_SPAN_DEFAULT,
    parameter logic [11:0] LEVEL_FRAMES = LEVEL_FRAMES_DEFAULT,
    parameter logic [9:0]  LFSR_SEED    = LFSR_SEED_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      game_over,
    input  logic [NUM_SLOTS*Y_W-1:0]  floor_y,
    output logic                      scroll_step,
    output logic [1:0]                speed_level,
    output logic                      respawn_valid,
    input  logic                      respawn_ready,
    output logic [SLOT_W-1:0]         respawn_slot,
    output logic [9:0]                respawn_x,
    output logic [9:0]                respawn_y,
    output logic [15:0]               depth,
    output logic [1:0]                state
);

    state_t state_reg, state_next;

    logic [2:0]           div_reg,   div_next;
    logic [11:0]          fcnt_reg,  fcnt_next;
    logic [1:0]           level_reg, level_next;
    logic [15:0]          depth_reg, depth_next;
    logic                 step_reg,  step_next;
    logic                 valid_reg, valid_next;
    logic [SLOT_W-1:0]    slot_reg,  slot_next;
    logic [9:0]           x_reg,     x_next;
    logic [NUM_SLOTS-1:0] lock_reg,  lock_next;

    logic [NUM_SLOTS-1:0] exited;
    logic [NUM_SLOTS-1:0] eligible;
    logic [SLOT_W-1:0]    pick;
    logic [9:0]           lfsr;
    logic                 start_game;
    logic                 run_tick;
    logic                 step_match;
    logic                 scan_en;
    logic                 raise;

    floor_lfsr10 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // ---------------- game state FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (game_over)  state_next = ST_OVER;
                else if (pause) state_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (game_over)   state_next = ST_OVER;
                else if (!pause) state_next = ST_RUN;
            end
            ST_OVER: begin
                if (!start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign start_game = (state_reg == ST_IDLE) && (state_next == ST_RUN);
    assign run_tick   = (state_reg == ST_RUN) && frame_tick;

    // ---------------- scroll pacing and level schedule ----------------
    always_comb begin
        step_match = 1'b0;
        case (level_reg)
            2'd0:    step_match = (div_reg[2:0] == 3'd0);
            2'd1:    step_match = (div_reg[1:0] == 2'd0);
            2'd2:    step_match = !div_reg[0];
            default: step_match = 1'b1;
        endcase
    end

    always_comb begin
        div_next   = div_reg;
        fcnt_next  = fcnt_reg;
        level_next = level_reg;
        depth_next = depth_reg;
        step_next  = 1'b0;
        if (start_game) begin
            div_next   = 3'd0;
            fcnt_next  = 12'd0;
            level_next = 2'd0;
            depth_next = 16'd0;
        end else if (run_tick) begin
            div_next  = div_reg + 3'd1;
            step_next = step_match;
            if (step_match && (depth_reg != 16'hFFFF)) begin
                depth_next = depth_reg + 16'd1;
            end
            if (fcnt_reg >= LEVEL_FRAMES - 12'd1) begin
                fcnt_next = 12'd0;
                if (level_reg != 2'd3) level_next = level_reg + 2'd1;
            end else begin
                fcnt_next = fcnt_reg + 12'd1;
            end
        end
    end

    // ---------------- respawn scan ----------------
    // A lock bit stays set while its floor is still below the screen, so the
    // generator has time to move y back up before the slot is considered again.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign exited[gi]    = (floor_y[gi*Y_W +: Y_W] >= BOTTOM_Y);
            assign eligible[gi]  = exited[gi] & ~lock_reg[gi];
            assign lock_next[gi] = start_game                      ? 1'b0 :
                                   !exited[gi]                     ? 1'b0 :
                                   (raise && (pick == SLOT_W'(gi))) ? 1'b1 :
                                   lock_reg[gi];
        end
    endgenerate

    always_comb begin
        pick = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (eligible[i]) pick = SLOT_W'(i);
        end
    end

    assign scan_en = ((state_reg == ST_RUN) || (state_reg == ST_PAUSED)) &&
                     (state_next != ST_OVER);
    assign raise   = scan_en && !valid_reg && (|eligible);

    always_comb begin
        valid_next = valid_reg;
        slot_next  = slot_reg;
        x_next     = x_reg;
        if (!scan_en) begin
            valid_next = 1'b0;
        end else if (raise) begin
            valid_next = 1'b1;
            slot_next  = pick;
            x_next     = wrap_x(lfsr, X_MIN, X_SPAN);
        end else if (valid_reg && respawn_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg   <= 3'd0;
            fcnt_reg  <= 12'd0;
            level_reg <= 2'd0;
            depth_reg <= 16'd0;
            step_reg  <= 1'b0;
            valid_reg <= 1'b0;
            slot_reg  <= '0;
            x_reg     <= X_MIN;
            lock_reg  <= '0;
        end else begin
            div_reg   <= div_next;
            fcnt_reg  <= fcnt_next;
            level_reg <= level_next;
            depth_reg <= depth_next;
            step_reg  <= step_next;
            valid_reg <= valid_next;
            slot_reg  <= slot_next;
            x_reg     <= x_next;
            lock_reg  <= lock_next;
        end
    end

    assign scroll_step   = step_reg;
    assign speed_level   = level_reg;
    assign respawn_valid = valid_reg;
    assign respawn_slot  = slot_reg;
    assign respawn_x     = x_reg;
    assign respawn_y     = TOP_Y;
    assign depth         = depth_reg;
    assign state         = state_reg;

endmodule

// File: tb/tb_floor_scroll_sched.sv
// Bench for floor_scroll_sched: directed stimulus with a step/respawn scoreboard
// checked by a monitor on the falling clock edge.
module tb_floor_scroll_sched;

    localparam logic [9:0]  SEED = 10'h2A5;
    localparam int          LF   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  y [4];
    logic [39:0] floor_y;
    logic        scroll_step;
    logic [1:0]  speed_level;
    logic        respawn_valid;
    logic        respawn_ready = 1'b0;
    logic [1:0]  respawn_slot;
    logic [9:0]  respawn_x;
    logic [9:0]  respawn_y;
    logic [15:0] depth;
    logic [1:0]  state;

    assign floor_y = {y[3], y[2], y[1], y[0]};

    floor_scroll_sched #(
        .LEVEL_FRAMES (12'(LF)),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .start         (start),
        .pause         (pause),
        .game_over     (game_over),
        .floor_y       (floor_y),
        .scroll_step   (scroll_step),
        .speed_level   (speed_level),
        .respawn_valid (respawn_valid),
        .respawn_ready (respawn_ready),
        .respawn_slot  (respawn_slot),
        .respawn_x     (respawn_x),
        .respawn_y     (respawn_y),
        .depth         (depth),
        .state         (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seen_steps = 0;

    logic step_q [$];
    int   resp_q [$];

    // spec-level model of pacing, run only while the bench has put the game in RUN
    bit   m_run = 0;
    int   m_div = 0, m_fcnt = 0, m_level = 0, m_depth = 0;
    logic [9:0] m_lfsr = SEED, m_lfsr_prev = SEED;
    bit   rst_prev = 1;
    bit   tick_prev = 0;
    bit   valid_prev = 0;
    logic [9:0] cur_exp_x = 10'd0;
    int   cur_slot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] lfsr_step(input logic [9:0] l);
        return {l[8:0], l[9] ^ l[6]};
    endfunction

    function automatic logic [9:0] exp_x(input logic [9:0] l);
        int r;
        r = int'(l[8:0]);
        if (r >= 480) r -= 480;
        return 10'(40 + r);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        logic e;
        e = 1'b0;
        if (m_run) begin
            case (m_level)
                0:       e = (m_div % 8 == 0);
                1:       e = (m_div % 4 == 0);
                2:       e = (m_div % 2 == 0);
                default: e = 1'b1;
            endcase
            m_div = (m_div + 1) % 8;
            if (e) m_depth++;
            if (m_fcnt == LF - 1) begin
                m_fcnt = 0;
                if (m_level < 3) m_level++;
            end else begin
                m_fcnt++;
            end
        end
        step_q.push_back(e);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic new_game_model();
        m_run = 1; m_div = 0; m_fcnt = 0; m_level = 0; m_depth = 0;
    endtask

    initial begin
        foreach (y[i]) y[i] = 10'd100;
        fork
            // monitor: scoreboard for scroll steps and respawn requests
            forever begin
                @(negedge clk);
                m_lfsr_prev = m_lfsr;
                m_lfsr      = rst_prev ? SEED : lfsr_step(m_lfsr);
                rst_prev    = rst;
                if (tick_prev) begin
                    if (step_q.size() == 0) chk("step_queue_underflow", 32'd1, 32'd0);
                    else chk("scroll_step", 32'(scroll_step), 32'(step_q.pop_front()));
                end else begin
                    chk("no_spurious_step", 32'(scroll_step), 32'd0);
                end
                tick_prev = frame_tick;
                if (scroll_step === 1'b1) seen_steps++;
                if (respawn_valid === 1'b1 && !valid_prev) begin
                    cur_exp_x = exp_x(m_lfsr_prev);
                    if (resp_q.size() == 0) begin
                        chk("unexpected_respawn_slot", 32'(respawn_slot), 32'd99);
                    end else begin
                        cur_slot = resp_q.pop_front();
                        chk("respawn_slot", 32'(respawn_slot), 32'(cur_slot));
                        chk("respawn_x", 32'(respawn_x), 32'(cur_exp_x));
                        chk("respawn_y", 32'(respawn_y), 32'd40);
                    end
                    $display("respawn request slot=%0d x=%0d y=%0d", respawn_slot, respawn_x, respawn_y);
                end
                if (respawn_valid === 1'b1 && respawn_ready) begin
                    chk("hs_slot", 32'(respawn_slot), 32'(cur_slot));
                    chk("hs_x", 32'(respawn_x), 32'(cur_exp_x));
                    $display("respawn accept  slot=%0d x=%0d", respawn_slot, respawn_x);
                end
                valid_prev = (respawn_valid === 1'b1);
            end
            begin
                // reset state
                cyc(3);
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_level", 32'(speed_level), 32'd0);
                chk("rst_depth", 32'(depth), 32'd0);
                chk("rst_valid", 32'(respawn_valid), 32'd0);
                chk("rst_slot", 32'(respawn_slot), 32'd0);
                chk("rst_x", 32'(respawn_x), 32'd40);
                chk("rst_y", 32'(respawn_y), 32'd40);
                rst = 1'b0;
                cyc(1);

                // pacing through all four levels
                start = 1'b1;
                cyc(1);
                new_game_model();
                chk("run_state", 32'(state), 32'd1);
                seen_steps = 0;
                for (int i = 0; i < 40; i++) tick();
                chk("pacing_steps", 32'(seen_steps), 32'd32);
                chk("pacing_depth", 32'(depth), 32'd32);
                chk("pacing_level", 32'(speed_level), 32'd3);

                // single respawn with back-pressure
                respawn_ready = 1'b0;
                resp_q.push_back(2);
                y[2] = 10'd470;
                cyc(1);
                chk("single_valid", 32'(respawn_valid), 32'd1);
                for (int i = 0; i < 5; i++) begin
                    cyc(1);
                    chk("hold_valid", 32'(respawn_valid), 32'd1);
                    chk("hold_slot", 32'(respawn_slot), 32'd2);
                    chk("hold_x", 32'(respawn_x), 32'(cur_exp_x));
                end
                respawn_ready = 1'b1;
                cyc(1);
                respawn_ready = 1'b0;
                chk("single_drop", 32'(respawn_valid), 32'd0);
                for (int i = 0; i < 5; i++) begin
                    cyc(1);
                    chk("locked_no_rerequest", 32'(respawn_valid), 32'd0);
                end
                y[2] = 10'd100;
                cyc(2);
                resp_q.push_back(2);
                y[2] = 10'd470;
                cyc(1);
                chk("rearm_valid", 32'(respawn_valid), 32'd1);
                respawn_ready = 1'b1;
                cyc(1);
                y[2] = 10'd100;
                cyc(2);

                // simultaneous exit, ready tied high
                resp_q.push_back(0);
                resp_q.push_back(3);
                y[0] = 10'd480;
                y[3] = 10'd475;
                cyc(8);
                chk("simul_served", 32'(resp_q.size()), 32'd0);
                chk("simul_idle", 32'(respawn_valid), 32'd0);
                y[0] = 10'd100;
                y[3] = 10'd100;
                respawn_ready = 1'b0;
                cyc(2);

                // game over with a pending request
                resp_q.push_back(1);
                y[1] = 10'd470;
                cyc(2);
                chk("go_pending", 32'(respawn_valid), 32'd1);
                game_over = 1'b1;
                cyc(1);
                game_over = 1'b0;
                m_run = 0;
                chk("go_state", 32'(state), 32'd3);
                chk("go_valid", 32'(respawn_valid), 32'd0);
                chk("go_depth", 32'(depth), 32'(m_depth));
                tick();
                tick();
                chk("over_depth_held", 32'(depth), 32'(m_depth));
                y[1] = 10'd100;
                start = 1'b0;
                cyc(1);
                chk("over_to_idle", 32'(state), 32'd0);
                start = 1'b1;
                cyc(1);
                new_game_model();
                chk("restart_state", 32'(state), 32'd1);
                chk("restart_depth", 32'(depth), 32'd0);
                chk("restart_level", 32'(speed_level), 32'd0);

                // pause mid-cadence at level 0, request completes while paused
                tick();
                tick();
                pause = 1'b1;
                cyc(1);
                m_run = 0;
                chk("paused_state", 32'(state), 32'd2);
                resp_q.push_back(3);
                y[3] = 10'd470;
                for (int i = 0; i < 20; i++) tick();
                chk("pause_depth", 32'(depth), 32'(m_depth));
                chk("pause_pending", 32'(respawn_valid), 32'd1);
                respawn_ready = 1'b1;
                cyc(1);
                respawn_ready = 1'b0;
                chk("pause_hs_drop", 32'(respawn_valid), 32'd0);
                y[3] = 10'd100;
                pause = 1'b0;
                cyc(1);
                m_run = 1;
                chk("resume_state", 32'(state), 32'd1);
                for (int i = 0; i < 8; i++) tick();
                chk("resume_depth", 32'(depth), 32'(m_depth));
                chk("resume_level", 32'(speed_level), 32'(m_level));

                // reset with a request pending
                resp_q.push_back(0);
                y[0] = 10'd470;
                cyc(2);
                chk("pre_rst_valid", 32'(respawn_valid), 32'd1);
                start = 1'b0;
                rst = 1'b1;
                cyc(1);
                m_run = 0;
                chk("midrst_valid", 32'(respawn_valid), 32'd0);
                chk("midrst_state", 32'(state), 32'd0);
                chk("midrst_lfsr", 32'(dut.u_lfsr.lfsr_reg), 32'(SEED));
                y[0] = 10'd100;
                rst = 1'b0;
                cyc(1);
                start = 1'b1;
                cyc(1);
                new_game_model();
                resp_q.push_back(2);
                respawn_ready = 1'b1;
                y[2] = 10'd470;
                cyc(4);
                chk("final_resp_empty", 32'(resp_q.size()), 32'd0);
                chk("final_step_empty", 32'(step_q.size()), 32'd0);

                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule

// File: doc/floor_scroll_sched.md
Name: floor_scroll_sched

Overview:
- Sequences the four-slot floor generator.
- Decides on which frames the floors advance one pixel (scroll_step), and raises that rate over time in four speed levels.
- Detects floors that have left the play area and issues respawn requests, with an LFSR-chosen x, over a valid/ready handshake.
- Sits between the game-state logic and the floor generator; runs on the system clock, paced by a one-cycle frame_tick.

Parameters:
- TOP_Y, 10'd40, y coordinate given to every respawned floor.
- BOTTOM_Y, 10'd470, a slot with y >= BOTTOM_Y counts as exited.
- X_MIN, 10'd40, lowest respawn x.
- X_SPAN, 10'd480, width of the respawn x range; legal range 256..512.
- LEVEL_FRAMES, 12'd1200, frames spent at each speed level before advancing.
- LFSR_SEED, 10'h2A5, LFSR value after reset; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  begin/restart game (level)
- pause  in  1  freeze scrolling (level)
- game_over  in  1  stop the game (pulse or level)
- floor_y  in  40  {y3,y2,y1,y0}, 10 bits each, current slot y values
- scroll_step  out  1  one-cycle pulse: generator adds 1 to every y
- speed_level  out  2  current level, 0..3
- respawn_valid  out  1  respawn request pending
- respawn_ready  in  1  generator accepts the request this cycle
- respawn_slot  out  2  slot index to reload
- respawn_x  out  10  new x for that slot
- respawn_y  out  10  new y for that slot, always TOP_Y
- depth  out  16  total scroll pixels this game (score)
- state  out  2  0 IDLE, 1 RUN, 2 PAUSED, 3 OVER

Behaviour:
- Reset values:
  - state IDLE; speed_level 0; depth 0; scroll_step 0; respawn_valid 0.
  - respawn_slot 0; respawn_x X_MIN; respawn_y TOP_Y.
  - lfsr LFSR_SEED; frame counter 0; divider 0; slot lock mask 0.
- FSM transitions:
  - IDLE -> RUN on start.
  - RUN -> PAUSED on pause.
  - PAUSED -> RUN when pause is low.
  - RUN or PAUSED -> OVER on game_over. game_over has priority over pause.
  - OVER -> IDLE when start is low; the next start begins a new game.
- Entering RUN from IDLE clears depth, speed_level, the frame counter, the divider and the lock mask.
- Scroll pacing (RUN only; frame_tick outside RUN has no effect):
  - On each frame_tick the divider increments.
  - scroll_step pulses the cycle after a tick whose pre-increment divider bits match:
    - level 0: divider[2:0] == 0 (1 step per 8 frames)
    - level 1: divider[1:0] == 0 (1 per 4)
    - level 2: divider[0] == 0 (1 per 2)
    - level 3: every tick
  - The divider is 3 bits and wraps.
  - depth increments with each scroll_step and saturates at 16'hFFFF.
- Level schedule:
  - The frame counter counts ticks in RUN.
  - On reaching LEVEL_FRAMES-1 it clears and speed_level increments.
  - speed_level saturates at 3.
- LFSR:
  - 10-bit Fibonacci, taps at bits 10 and 7.
  - Advances every clock regardless of state.
  - Never reaches 0.
- Respawn scan (RUN and PAUSED):
  - A slot is eligible when y_i >= BOTTOM_Y and lock[i] == 0.
  - When respawn_valid is low and some slot is eligible, pick the lowest eligible index.
  - Next cycle: respawn_valid=1, respawn_slot=i, lock[i]=1, and respawn_x captured from the LFSR.
  - respawn_x = X_MIN + r, where r = lfsr[8:0], minus X_SPAN if lfsr[8:0] >= X_SPAN.
- Handshake:
  - slot, x and y stay stable while valid && !ready.
  - The request completes on the cycle valid && ready; valid drops the next cycle.
  - A new request may be raised the cycle after that.
  - Only one request is outstanding at a time.
- lock[i] clears on any cycle where y_i < BOTTOM_Y, which prevents a double respawn while the generator updates y.
- Scrolling continues while a request is pending; the two are independent.
- Entering OVER drops respawn_valid immediately and abandons the request.
- rst mid-game returns everything to reset values on the next edge, including dropping a pending valid.

Decomposition:
- Shared package floor_pkg holds:
  - the state encoding (ST_IDLE..ST_OVER)
  - NUM_SLOTS=4
  - the screen bounds (TOP_Y, BOTTOM_Y, X_MIN, X_SPAN defaults)
- One sub-module, floor_lfsr10 (seed parameter, free-running output), reusable by other randomised blocks.

Test Plan:
- Pacing and level 3:
  - Stimulus: rst, start, LEVEL_FRAMES=4, 40 frame_ticks, all floor_y=100.
  - Required response: 1 step per 8 ticks during frames 0-3, then 1/4, 1/2, every tick; speed_level ends at 3 and stays.
- Single respawn:
  - Stimulus: in RUN, y2 goes to 470.
  - Required response: valid with slot=2, y=40, and x in [40,519].
  - With ready held low for 5 cycles, the fields stay stable; ready=1 completes; valid drops.
  - y2 stays at 470 with no second request until y2 < 470 and then >= 470 again.
- Simultaneous exit:
  - Stimulus: y0=480 and y3=475 on the same cycle, ready tied high.
  - Required response: slot 0 served first, slot 3 next, never both at once.
- Pause:
  - Stimulus: pause for 20 ticks.
  - Required response: no scroll_step, divider and depth frozen; a pending respawn still completes; resume restores the same cadence.
- Game over and restart:
  - Stimulus: game_over with valid pending and depth=57.
  - Required response: state=OVER, valid=0, depth held at 57.
  - start low then high: state RUN, depth 0, speed_level 0.
- Reset mid-request:
  - Stimulus: rst while valid=1.
  - Required response: next cycle valid=0, state IDLE, lfsr=LFSR_SEED.
